// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder built from two half adders and an OR for the carry.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    // Sum and carry of two bits.
    always_comb begin
        s = a ^ b;
        c = a & b;
    end

endmodule

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic ha0_s;
    logic ha0_c;
    logic ha1_c;

    half_adder u_ha0 (
        .a (a),
        .b (b),
        .s (ha0_s),
        .c (ha0_c)
    );

    half_adder u_ha1 (
        .a (ha0_s),
        .b (ci),
        .s (s),
        .c (ha1_c)
    );

    // Carry out is set by either half adder.
    always_comb begin
        co = ha0_c | ha1_c;
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full-adder cell sequenced LSB-first over WIDTH cycles.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               last_bit;
    logic               bit_s;
    logic               bit_c;

    full_adder_cell u_cell (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (bit_s),
        .co (bit_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; in_ready is a register so the post-reset cycle cannot accept.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_bit   = 1'b0;
        case (state)
            IDLE: begin
                accept = in_valid && in_ready;
                if (accept) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                last_bit = (cnt == CNT_W'(WIDTH - 1));
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake/status outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            busy      <= (state_next != IDLE);
        end
    end

    // Operand shifters, carry flop, bit counter, sum shifter and carry-out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            carry <= bit_c;
            sum   <= {bit_s, sum[WIDTH-1:1]};
            if (last_bit) begin
                cout <= bit_c;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule
